// File: rtl/uart_frame_sched_pkg.sv
// Shared types and frame constants for the UART frame scheduler.
// Optional macro UART_FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
package uart_frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_e;

  localparam logic [7:0] HDR_BASE_DEF    = 8'hA0;
  localparam int         FRAME_LEN_PLAIN = 3;
  localparam int         FRAME_LEN_CSUM  = 4;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  localparam logic [1:0] IDX_LAST = 2'(FRAME_LEN - 1);

  // Byte idx of the frame carrying word data behind header hdr.
  function automatic logic [7:0] frame_byte(input logic [7:0]  hdr,
                                            input logic [15:0] data,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0:    b = hdr;
      2'd1:    b = data[15:8];
      2'd2:    b = data[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      2'd3:    b = hdr ^ data[15:8] ^ data[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not granted last time wins.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic [1:0] grant_onehot_o,
  output logic       grant_id_o
);

  logic last_grant_q;

  always_comb begin
    grant_id_o     = (valid_i == 2'b11) ? ~last_grant_q : valid_i[1];
    grant_onehot_o = 2'b00;
    if (valid_i != 2'b00) begin
      grant_onehot_o = grant_id_o ? 2'b10 : 2'b01;
    end
  end

  // Resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (update_i && (valid_i != 2'b00)) begin
      last_grant_q <= grant_id_o;
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Shares one start/busy UART transmitter between two 16-bit word requesters as byte frames.
// Define UART_FRAME_CHECKSUM_EN for 4-byte frames with a trailing XOR checksum.
module uart_frame_sched
  import uart_frame_sched_pkg::*;
#(
  parameter logic [7:0]  HDR_BASE   = HDR_BASE_DEF,
  parameter logic [15:0] GAP_CYCLES = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        grant_id,
  output state_e      dbg_state
);

  // Handshakes: reqN_ready is a one-cycle pulse in the cycle the word is taken
  // (reqN_valid already high); tx_start pulses once per byte only while tx_busy is
  // low, and tx_data holds from that pulse until tx_busy has risen and fallen again.

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        grant_id_q, grant_id_d;
  logic        frame_busy_q, frame_busy_d;
  logic        arb_update;
  logic [1:0]  arb_onehot;
  logic        arb_id;
  logic [7:0]  hdr;

  uart_rr_arb2 u_arb (
    .clk            (clk),
    .rst            (rst),
    .valid_i        ({req1_valid, req0_valid}),
    .update_i       (arb_update),
    .grant_onehot_o (arb_onehot),
    .grant_id_o     (arb_id)
  );

  assign hdr = HDR_BASE | {7'd0, grant_id_q};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    data_d       = data_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    frame_busy_d = frame_busy_q;
    arb_update   = 1'b0;
    tx_start     = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else if ((req0_valid || req1_valid) && !rst) begin
          arb_update   = 1'b1;
          data_d       = arb_id ? req1_data : req0_data;
          grant_id_d   = arb_id;
          frame_busy_d = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_d = frame_byte(hdr, data_q, idx_q);
        state_d   = ST_START;
      end
      // A busy transmitter here may belong to someone else; just wait for it.
      ST_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == IDX_LAST) begin
            frame_done   = 1'b1;
            frame_busy_d = 1'b0;
            idx_d        = 2'd0;
            gap_d        = GAP_CYCLES;
            state_d      = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      gap_q        <= 16'd0;
      data_q       <= 16'd0;
      tx_data_q    <= 8'd0;
      grant_id_q   <= 1'b0;
      frame_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      data_q       <= data_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      frame_busy_q <= frame_busy_d;
    end
  end

  assign req0_ready = arb_update & arb_onehot[0];
  assign req1_ready = arb_update & arb_onehot[1];
  assign tx_data    = tx_data_q;
  assign frame_busy = frame_busy_q;
  assign grant_id   = grant_id_q;
  assign dbg_state  = state_q;

endmodule
